// File: rtl/line_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : line_sched
//  Purpose  : Per-scanline tile/sprite render sequencer with ping-pong bank
//             flip and overrun detection. Optional macro LINE_SCHED_STATS_EN
//             adds the overrun and frame counters.
//  Revision : 1.0 - initial release
// ============================================================================
module line_sched #(
    parameter int HSWITCH = 1590,
    parameter int HTOTAL  = 1600,
    parameter int VACTIVE = 480,
    parameter int VTOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        enable,
    input  logic        clr_overrun,
    input  logic        tile_done,
    input  logic        sprite_done,
    output logic        tile_start,
    output logic        sprite_start,
    output logic        wren_tile_draw,
    output logic        switch,
    output logic        abort,
    output logic        busy,
    output logic        overrun_sticky,
    output logic [15:0] overrun_cnt,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_TILE_START = 3'd1;
    localparam logic [2:0] S_TILE_WAIT  = 3'd2;
    localparam logic [2:0] S_SPR_START  = 3'd3;
    localparam logic [2:0] S_SPR_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [10:0] c_hswitch    = 11'(HSWITCH);
    localparam logic [10:0] c_hlast      = 11'(HTOTAL - 1);
    localparam logic [9:0]  c_vrender_end = 10'(VACTIVE - 1);
    localparam logic [9:0]  c_vlast      = 10'(VTOTAL - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       w_overrun;
    logic       w_render;
    logic       w_hsw;
    logic       w_frame_end;
    logic       w_tile_start_nxt;
    logic       w_sprite_start_nxt;
    logic       w_wren_nxt;
    logic       w_busy_nxt;

    logic r_tile_start, r_sprite_start, r_wren, r_switch, r_abort, r_busy, r_sticky;

    // A render line prepares the line shown next, hence the last blanking line too.
    assign w_render    = (vcount < c_vrender_end) || (vcount == c_vlast);
    assign w_hsw       = (hcount == c_hswitch);
    assign w_frame_end = (hcount == c_hlast) && (vcount == c_vlast);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_overrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (hcount == 11'd0 && w_render && enable) w_state_nxt = S_TILE_START;
            end
            S_TILE_START: begin
                if (w_hsw) begin
                    w_overrun   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_TILE_WAIT;
                end
            end
            S_TILE_WAIT: begin
                if (w_hsw) begin
                    w_overrun   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (tile_done) begin
                    w_state_nxt = S_SPR_START;
                end
            end
            S_SPR_START: begin
                if (w_hsw) begin
                    w_overrun   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SPR_WAIT;
                end
            end
            S_SPR_WAIT: begin
                // A sprite finish on the flip cycle still counts as on time.
                if (sprite_done) begin
                    w_state_nxt = w_hsw ? S_IDLE : S_DONE;
                end else if (w_hsw) begin
                    w_overrun   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (w_hsw) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tile_start_nxt   = (w_state_nxt == S_TILE_START);
        w_sprite_start_nxt = (w_state_nxt == S_SPR_START);
        w_wren_nxt         = (w_state_nxt == S_TILE_START) || (w_state_nxt == S_TILE_WAIT);
        w_busy_nxt         = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tile_start   <= 1'b0;
            r_sprite_start <= 1'b0;
            r_wren         <= 1'b0;
            r_switch       <= 1'b0;
            r_abort        <= 1'b0;
            r_busy         <= 1'b0;
            r_sticky       <= 1'b0;
        end else begin
            r_tile_start   <= w_tile_start_nxt;
            r_sprite_start <= w_sprite_start_nxt;
            r_wren         <= w_wren_nxt;
            r_abort        <= w_overrun;
            r_busy         <= w_busy_nxt;
            if (w_hsw && w_render) r_switch <= ~r_switch;
            if (clr_overrun)       r_sticky <= 1'b0;
            else if (w_overrun)    r_sticky <= 1'b1;
        end
    end

    assign tile_start     = r_tile_start;
    assign sprite_start   = r_sprite_start;
    assign wren_tile_draw = r_wren;
    assign switch         = r_switch;
    assign abort          = r_abort;
    assign busy           = r_busy;
    assign overrun_sticky = r_sticky;

`ifdef LINE_SCHED_STATS_EN
    logic [15:0] r_overrun_cnt;
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overrun_cnt <= 16'd0;
            r_frame_cnt   <= 16'd0;
        end else begin
            if (clr_overrun)                               r_overrun_cnt <= 16'd0;
            else if (w_overrun && r_overrun_cnt != 16'hFFFF) r_overrun_cnt <= r_overrun_cnt + 16'd1;
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
    assign frame_cnt   = r_frame_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_frame_end;
    assign overrun_cnt    = 16'd0;
    assign frame_cnt      = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_line_sched
//  Purpose  : Scoreboard bench for line_sched; expectations come from a
//             per-line interval model of the scheduling rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_sched;

    localparam int HSW = 1590;
    localparam int HT  = 1600;
    localparam int VA  = 480;
    localparam int VT  = 525;
    localparam int BIG = 100000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        enable, clr_overrun, tile_done, sprite_done;
    logic        tile_start, sprite_start, wren_tile_draw, switch, abort, busy, overrun_sticky;
    logic [15:0] overrun_cnt, frame_cnt;

    always #5 clk = ~clk;

    line_sched #(.HSWITCH(HSW), .HTOTAL(HT), .VACTIVE(VA), .VTOTAL(VT)) dut (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .enable(enable), .clr_overrun(clr_overrun), .tile_done(tile_done),
        .sprite_done(sprite_done), .tile_start(tile_start), .sprite_start(sprite_start),
        .wren_tile_draw(wren_tile_draw), .switch(switch), .abort(abort), .busy(busy),
        .overrun_sticky(overrun_sticky), .overrun_cnt(overrun_cnt), .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic        ts, ss, wren, sw, abort, busy, sticky;
        logic [15:0] ocnt, fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    bit m_sw, m_sticky;
    int m_ocnt, m_fcnt;

    always @(negedge clk) begin
        exp_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {tile_start, sprite_start, wren_tile_draw, switch, abort, busy,
                 overrun_sticky, overrun_cnt, frame_cnt};
            n_chk++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs at h=%0d v=%0d: got ts=%b ss=%b wren=%b sw=%b abort=%b busy=%b sticky=%b ocnt=%0d fcnt=%0d, expected ts=%b ss=%b wren=%b sw=%b abort=%b busy=%b sticky=%b ocnt=%0d fcnt=%0d",
                         hcount, vcount, a.ts, a.ss, a.wren, a.sw, a.abort, a.busy, a.sticky, a.ocnt, a.fcnt,
                         e.ts, e.ss, e.wren, e.sw, e.abort, e.busy, e.sticky, e.ocnt, e.fcnt);
            end
        end
    end

    task automatic step(input int h, input int v, input bit en, input bit clr,
                        input bit td, input bit sd, input bit rn, input exp_t e);
        hcount      = 11'(h);
        vcount      = 10'(v);
        enable      = en;
        clr_overrun = clr;
        tile_done   = td;
        sprite_done = sd;
        reset_n     = rn;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // One scanline. Indices (td, sd, clr, rk) refer to positions in the hcount
    // walk; -1 disables. Compressed lines visit only hcount 0..31 and 1584..1599.
    task automatic run_line(input int v, input bit dense, input bit en0, input int edrop,
                            input int td, input int sd, input int clr, input int rk);
        int  hs[$];
        int  i_s;
        bit  r, started, tile_ok, done_ok, killed;
        int  te;
        if (dense) begin
            for (int h = 0; h < HT; h++) hs.push_back(h);
        end else begin
            for (int h = 0; h < 32; h++) hs.push_back(h);
            for (int h = 1584; h < HT; h++) hs.push_back(h);
        end
        i_s = 0;
        foreach (hs[k]) if (hs[k] == HSW) i_s = k;
        r       = (v < VA - 1) || (v == VT - 1);
        started = r && en0 && (rk != 0);
        tile_ok = (td >= 2) && (td < i_s);
        te      = tile_ok ? td : i_s;
        done_ok = tile_ok && (sd >= td + 2) && (sd <= i_s);
        killed  = 1'b0;
        for (int i = 0; i < hs.size(); i++) begin
            exp_t e;
            bit   rlow, act;
            e    = '0;
            rlow = (rk >= 0) && (i == rk || i == rk + 1);
            if (rlow) begin
                killed   = 1'b1;
                m_sw     = 1'b0;
                m_sticky = 1'b0;
                m_ocnt   = 0;
                m_fcnt   = 0;
            end else begin
                act    = started && !killed;
                e.ts   = act && (i == 0);
                e.wren = act && (i < te);
                e.ss   = act && tile_ok && (i == td);
                e.busy = act && (i < i_s);
                e.abort = act && !done_ok && (i == i_s);
                if (i == i_s && r) m_sw = !m_sw;
                if (clr == i) begin
                    m_sticky = 1'b0;
                    m_ocnt   = 0;
                end else if (e.abort) begin
                    m_sticky = 1'b1;
                    if (m_ocnt < 65535) m_ocnt++;
                end
                if (hs[i] == HT - 1 && v == VT - 1) m_fcnt = (m_fcnt + 1) % 65536;
                e.sw     = m_sw;
                e.sticky = m_sticky;
`ifdef LINE_SCHED_STATS_EN
                e.ocnt = 16'(m_ocnt);
                e.fcnt = 16'(m_fcnt);
`endif
            end
            step(hs[i], v, (i < edrop) ? en0 : 1'b0, clr == i, td == i, sd == i, !rlow, e);
        end
    endtask

    initial begin
        int td, sd, clr, rk, v;
        bit en;
        m_sw = 0; m_sticky = 0; m_ocnt = 0; m_fcnt = 0;
        hcount = '0; vcount = '0; enable = 0; clr_overrun = 0;
        tile_done = 0; sprite_done = 0; reset_n = 0;
        repeat (3) step(HT - 1, 500, 0, 0, 0, 0, 0, '0);

        run_line(10, 1, 1, BIG, 200, 900, -1, -1);   // normal line
        run_line(11, 1, 1, BIG, 200, -1, -1, -1);    // sprite never finishes
        run_line(12, 1, 1, BIG, 50, 100, -1, -1);    // next line starts normally
        run_line(13, 1, 1, BIG, 300, HSW, -1, -1);   // sprite_done on flip cycle
        run_line(14, 1, 1, BIG, 300, -1, HSW, -1);   // clear collides with overrun
        run_line(15, 1, 1, 500, 200, 900, -1, -1);   // enable dropped mid-line
        run_line(16, 0, 0, BIG, 5, 10, -1, -1);
        run_line(17, 0, 0, BIG, 5, 10, -1, -1);
        run_line(18, 0, 1, BIG, -1, -1, -1, 5);      // reset during TILE_WAIT
        run_line(19, 0, 1, BIG, 10, 20, -1, -1);

        for (int l = 0; l < VT; l++) begin
            td  = $urandom_range(1, 24);
            sd  = td + $urandom_range(1, 17);
            clr = ($urandom_range(0, 15) == 0) ? $urandom_range(30, 40) : -1;
            run_line(l, 0, 1, BIG, td, sd, clr, -1);
        end

        for (int l = 0; l < 80; l++) begin
            v   = $urandom_range(0, VT - 1);
            en  = ($urandom_range(0, 3) != 0);
            td  = $urandom_range(1, 30);
            sd  = td + $urandom_range(1, 12);
            clr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 47) : -1;
            rk  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 30) : -1;
            run_line(v, 0, en, BIG, td, sd, clr, rk);
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_sched.md
# line_sched

Per-scanline render scheduler for the ping-pong line buffer. On each render line it sequences the tile engine and then the sprite engine, drives the tile write-enable and the display/draw bank `switch`, and detects lines whose rendering did not finish before the bank flip. It sits between `vga_counters` and the tile/sprite engines and replaces ad-hoc start logic in the VGA top level.

## Interface
Parameters:
- `HSWITCH`, 1590: hcount at which the buffer bank flips.
- `HTOTAL`, 1600: hcount period.
- `VACTIVE`, 480: active lines.
- `VTOTAL`, 525: total lines.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset_n` in 1: synchronous, active-low reset.
- `hcount` in 11: horizontal count from `vga_counters`.
- `vcount` in 10: vertical count from `vga_counters`.
- `enable` in 1: allows new lines to start. Driven from `ctrl_reg`.
- `clr_overrun` in 1: one-cycle pulse; clears `overrun_sticky` and `overrun_cnt`.
- `tile_done` in 1: tile engine finished the line.
- `sprite_done` in 1: sprite engine finished the line.
- `tile_start` out 1: one-cycle start pulse to the tile engine.
- `sprite_start` out 1: one-cycle start pulse to the sprite engine.
- `wren_tile_draw` out 1: tile write-enable into the draw bank.
- `switch` out 1: bank select; toggles once per render line.
- `abort` out 1: one-cycle pulse; the engines must abandon the current line.
- `busy` out 1: state is not IDLE.
- `overrun_sticky` out 1: set by any overrun.
- `overrun_cnt` out 16: count of overrun lines.
- `frame_cnt` out 16: count of completed frames.

## Operation
- Render line: `vcount < VACTIVE-1` or `vcount == VTOTAL-1`. A render line renders the line displayed next.
- States: IDLE, TILE_START, TILE_WAIT, SPR_START, SPR_WAIT, DONE.
- IDLE → TILE_START: when `hcount == 0`, the line is a render line, and `enable` is 1.
- TILE_START: `tile_start` = 1 and `wren_tile_draw` = 1. Always moves to TILE_WAIT next cycle. Any `tile_done` seen in this state is ignored.
- TILE_WAIT: `wren_tile_draw` stays 1. On `tile_done` → SPR_START.
- SPR_START: `sprite_start` = 1 and `wren_tile_draw` = 0. Moves to SPR_WAIT next cycle.
- SPR_WAIT: on `sprite_done` → DONE.
- DONE: held until `hcount == HSWITCH`, then → IDLE.
- Bank flip: at `hcount == HSWITCH` on a render line, `switch` toggles. It toggles regardless of `enable` and regardless of state.
- Overrun:
  - Condition: at `hcount == HSWITCH`, state is TILE_START, TILE_WAIT, SPR_START, or SPR_WAIT.
  - Response: `abort` = 1 for one cycle, `overrun_sticky` ← 1, `overrun_cnt` += 1 (saturates at 16'hFFFF), state → IDLE.
- Simultaneous: `sprite_done` in SPR_WAIT on the `HSWITCH` cycle counts as completed, with no overrun. `tile_done` in the same cycle counts as an overrun.
- `clr_overrun` in the same cycle as an overrun: the clear wins and the overrun is not counted.
- `enable` dropped mid-line: the current line completes normally; no further lines start.
- `frame_cnt` += 1 (wraps) at `hcount == HTOTAL-1` and `vcount == VTOTAL-1`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, all pulses 0, `wren_tile_draw` 0, `switch` 0, `busy` 0, `overrun_sticky` 0, both counters 0.
- Start latency: `hcount == 0` is sampled, so `tile_start` is high during `hcount == 1`.
- `tile_done` sampled at cycle N → `wren_tile_draw` low and `sprite_start` high at N+1.
- `switch` and `abort` change in the cycle after the `HSWITCH` sample, i.e. visible at `hcount == HSWITCH+1`.
- `reset_n` low mid-line forces IDLE on the next edge with no `abort` pulse. The engines are reset by the same signal.
- `busy` reflects the registered state: 1 from the `tile_start` cycle through the cycle before returning to IDLE.

## Configuration
- `LINE_SCHED_STATS_EN` defined: `overrun_cnt` and `frame_cnt` are implemented as described.
- Not defined:
  - Both counters are tied to 0 and their registers are removed.
  - `overrun_sticky`, `abort`, and `clr_overrun` behave identically.

## Test plan
- Normal line: `enable` = 1, line 10, `tile_done` at hcount 200, `sprite_done` at hcount 900.
  - Required: `tile_start` high at hcount 1 only.
  - Required: `wren_tile_draw` high over hcount 1..200.
  - Required: `sprite_start` high at hcount 201.
  - Required: `switch` toggles at hcount 1591; `abort` never asserted.
- Overrun: `sprite_done` withheld.
  - Required: `abort` high at hcount 1591, `overrun_sticky` = 1, `overrun_cnt` = 1, state IDLE.
  - Required: the next line starts normally at hcount 1.
- Simultaneous: `sprite_done` on the `hcount == 1590` cycle.
  - Required: no `abort`, `overrun_cnt` unchanged.
  - Repeat with `clr_overrun` on the same cycle as an overrun: required `overrun_cnt` = 0.
- Line gating:
  - Lines 479–523: no `tile_start`, `switch` constant.
  - Line 524: `tile_start` at hcount 1.
  - After a full frame: `frame_cnt` = 1 (`LINE_SCHED_STATS_EN` defined) or 0 (not defined).
- `enable` = 0 at hcount 500 mid-line: the line completes; no `tile_start` on later lines; `switch` still toggles each render line.
- `reset_n` low for 2 cycles during TILE_WAIT: all outputs at reset values; the next render line starts at hcount 1.
